// File: rtl/demux16_pkg.sv
// demux16_pkg
//   Shared definitions for the demux_16_seq scatter block: channel count,
//   select width, the status FSM state type and the channel slice helper.
//   Used by demux16_chan and demux_16_seq.
package demux16_pkg;

    localparam int NCH   = 16;
    localparam int SEL_W = 4;

    // Status-only control FSM; instantiated only when DEMUX16_COUNT_EN is defined.
    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    // LSB position of channel k on a flat NCH*width bus.
    function automatic int chan_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/demux16_chan.sv
// demux16_chan
//   Single-entry channel buffer for demux_16_seq.
//   Ports:
//     clock    rising-edge clock
//     reset    asynchronous active-low reset
//     i_load   write i_data into the buffer and mark it valid
//     i_data   word to store
//     i_ack    consumer takes the stored word (ignored when empty)
//     o_data   stored word; held after ack, cleared only by reset
//     o_valid  buffer holds a word
module demux16_chan #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ack,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // A load in the same cycle as an ack wins, so the buffer stays valid
    // and takes the new word without a bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_ack) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/demux_16_seq.sv
// demux_16_seq
//   Registered 1-to-16 demultiplexer / scatter sequencer. Accepts a word
//   stream over valid/ready and writes each word into one of 16 single-entry
//   channel buffers chosen by an explicit select or an auto-increment pointer.
//   Ports:
//     clock, reset            rising-edge clock, async active-low reset
//     in_data/in_valid/in_ready  input word handshake
//     select                  explicit destination (auto_mode = 0)
//     auto_mode               1 = destination is ptr
//     ptr_clear               synchronous pointer (and counter) clear
//     ptr                     current auto pointer
//     out_data                flat bus, channel k at [k*WIDTH +: WIDTH]
//     out_valid/out_ack       per-channel valid and consumer acknowledge
//   Optional macro DEMUX16_COUNT_EN adds accept_count and stall_cycles
//   status counters driven by an IDLE/STALL status FSM.
module demux_16_seq
    import demux16_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     select,
    input  logic                 auto_mode,
    input  logic                 ptr_clear,
    output logic [SEL_W-1:0]     ptr,
`ifdef DEMUX16_COUNT_EN
    output logic [15:0]          accept_count,
    output logic [15:0]          stall_cycles,
`endif
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ack
);

    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_dest;
    logic             w_accept;
    logic [NCH-1:0]   w_load;

    assign w_dest   = auto_mode ? r_ptr : select;
    // Ready depends only on the selected channel, never on in_valid.
    assign in_ready = ~out_valid[w_dest] | out_ack[w_dest];
    assign w_accept = in_valid & in_ready;
    assign ptr      = r_ptr;

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        assign w_load[k] = w_accept & (w_dest == SEL_W'(k));

        demux16_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .i_load  (w_load[k]),
            .i_data  (in_data),
            .i_ack   (out_ack[k]),
            .o_data  (out_data[chan_lsb(k, WIDTH) +: WIDTH]),
            .o_valid (out_valid[k])
        );
    end

    // Clear beats increment; an accept in the clear cycle has already used
    // the old pointer as its destination.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (ptr_clear) begin
            r_ptr <= '0;
        end else if (w_accept && auto_mode) begin
            r_ptr <= r_ptr + SEL_W'(1);
        end
    end

`ifdef DEMUX16_COUNT_EN
    state_t      r_state;
    logic [15:0] r_accept_count;
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_accept_count <= '0;
            r_stall_cycles <= '0;
        end else begin
            case (r_state)
                IDLE:    if (in_valid && !in_ready) r_state <= STALL;
                STALL:   if (w_accept || !in_valid) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (ptr_clear) begin
                r_accept_count <= '0;
                r_stall_cycles <= '0;
            end else begin
                if (w_accept)
                    r_accept_count <= r_accept_count + 16'd1;
                if (r_state == STALL && r_stall_cycles != '1)
                    r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign accept_count = r_accept_count;
    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_demux_16_seq.sv
module tb_demux_16_seq;

    logic          clock;
    logic          reset;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    select;
    logic          auto_mode;
    logic          ptr_clear;
    logic [3:0]    ptr;
    logic [511:0]  out_data;
    logic [15:0]   out_valid;
    logic [15:0]   out_ack;
`ifdef DEMUX16_COUNT_EN
    logic [15:0]   accept_count;
    logic [15:0]   stall_cycles;
`endif

    typedef struct packed {
        logic [3:0]  ch;
        logic [31:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_ptr;
    int         n_checks;
    int         n_pass;

    demux_16_seq #(
        .WIDTH (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .select    (select),
        .auto_mode (auto_mode),
        .ptr_clear (ptr_clear),
        .ptr       (ptr),
`ifdef DEMUX16_COUNT_EN
        .accept_count (accept_count),
        .stall_cycles (stall_cycles),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] chan(input int k);
        return out_data[k*32 +: 32];
    endfunction

    // Drive one word, wait (bounded) for acceptance, then compare the
    // scoreboard entry against the channel the word should have landed in.
    task automatic send(input logic [31:0] d, input logic [3:0] sel, input logic am,
                        input logic [15:0] ack, input logic clr, output int waits);
        exp_t e;
        logic ok;
        in_data   = d;
        select    = sel;
        auto_mode = am;
        out_ack   = ack;
        ptr_clear = clr;
        in_valid  = 1'b1;
        ok    = 1'b0;
        waits = 0;
        while (!ok && waits < 40) begin
            @(negedge clock);
            if (in_ready === 1'b1) begin
                ok     = 1'b1;
                e.ch   = am ? m_ptr : sel;
                e.data = d;
                sb.push_back(e);
            end
            @(posedge clock); #1;
            if (!ok) waits++;
        end
        in_valid  = 1'b0;
        out_ack   = '0;
        ptr_clear = 1'b0;
        if (clr) m_ptr = '0;
        else if (ok && am) m_ptr = m_ptr + 4'd1;

        n_checks++;
        if (!ok) $display("FAIL send_timeout data=%h got no in_ready, need accept", d);
        else n_pass++;

        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (chan(int'(e.ch)) !== e.data)
                $display("FAIL send_data ch=%0d got=%h exp=%h", e.ch, chan(int'(e.ch)), e.data);
            else n_pass++;
            n_checks++;
            if (out_valid[e.ch] !== 1'b1)
                $display("FAIL send_valid ch=%0d got=%b exp=1", e.ch, out_valid[e.ch]);
            else n_pass++;
        end
        n_checks++;
        if (ptr !== m_ptr) $display("FAIL send_ptr got=%0d exp=%0d", ptr, m_ptr);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        select    = '0;
        auto_mode = 1'b0;
        ptr_clear = 1'b0;
        out_ack   = '0;
        m_ptr     = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (out_valid !== 16'h0000) $display("FAIL reset_valid got=%h exp=0000", out_valid);
        else n_pass++;
        n_checks++;
        if (ptr !== 4'd0) $display("FAIL reset_ptr got=%0d exp=0", ptr);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready);
        else n_pass++;
        n_checks++;
        if (out_data !== '0) $display("FAIL reset_data got nonzero exp=0");
        else n_pass++;
    endtask

    task automatic test_scatter();
        int w;
        for (int i = 0; i < 16; i++)
            send(32'(i), 4'(i), 1'b0, 16'h0000, 1'b0, w);
        n_checks++;
        if (out_valid !== 16'hFFFF) $display("FAIL scatter_valid got=%h exp=ffff", out_valid);
        else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (chan(k) !== 32'(k)) $display("FAIL scatter_ch%0d got=%h exp=%h", k, chan(k), 32'(k));
            else n_pass++;
        end
        // 17th word to full channel 3 must stall until acked.
        in_data  = 32'h0000_0111;
        select   = 4'd3;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL full_stall cyc=%0d got=%b exp=0", c, in_ready);
            else n_pass++;
            @(posedge clock); #1;
        end
        send(32'h0000_0111, 4'd3, 1'b0, 16'h0008, 1'b0, w);
        n_checks++;
        if (w !== 0) $display("FAIL full_release waits got=%0d exp=0", w);
        else n_pass++;
        n_checks++;
        if (out_valid !== 16'hFFFF) $display("FAIL full_valid got=%h exp=ffff", out_valid);
        else n_pass++;
    endtask

    task automatic test_auto_wrap();
        int w;
        for (int i = 0; i < 18; i++)
            send(32'(100 + i), 4'd0, 1'b1, 16'hFFFF, 1'b0, w);
        n_checks++;
        if (chan(0) !== 32'd116) $display("FAIL wrap_ch0 got=%0d exp=116", chan(0));
        else n_pass++;
        n_checks++;
        if (chan(1) !== 32'd117) $display("FAIL wrap_ch1 got=%0d exp=117", chan(1));
        else n_pass++;
        n_checks++;
        if (ptr !== 4'd2) $display("FAIL wrap_ptr got=%0d exp=2", ptr);
        else n_pass++;
        n_checks++;
        if (out_valid !== 16'h0002) $display("FAIL wrap_valid got=%h exp=0002", out_valid);
        else n_pass++;
        out_ack = '1;
        @(posedge clock); #1;
        out_ack = '0;
        n_checks++;
        if (out_valid !== 16'h0000) $display("FAIL drain_valid got=%h exp=0000", out_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int w;
        send(32'hAAAA_AAAA, 4'd5, 1'b0, 16'h0000, 1'b0, w);
        select    = 4'd6;
        auto_mode = 1'b0;
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL no_hol got=%b exp=1", in_ready);
        else n_pass++;
        select = 4'd5;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL ch5_full got=%b exp=0", in_ready);
        else n_pass++;
        @(posedge clock); #1;
        send(32'hBBBB_BBBB, 4'd5, 1'b0, 16'h0020, 1'b0, w);
        n_checks++;
        if (w !== 0) $display("FAIL passthru_ready waits got=%0d exp=0", w);
        else n_pass++;
    endtask

    task automatic test_ptr_clear();
        int w;
        ptr_clear = 1'b1;
        @(posedge clock); #1;
        ptr_clear = 1'b0;
        m_ptr = '0;
        n_checks++;
        if (ptr !== 4'd0) $display("FAIL clear_ptr got=%0d exp=0", ptr);
        else n_pass++;
        for (int i = 0; i < 9; i++)
            send(32'(200 + i), 4'd0, 1'b1, 16'hFFFF, 1'b0, w);
        n_checks++;
        if (ptr !== 4'd9) $display("FAIL ptr_nine got=%0d exp=9", ptr);
        else n_pass++;
        send(32'd7, 4'd0, 1'b1, 16'hFFFF, 1'b1, w);
        n_checks++;
        if (chan(9) !== 32'd7) $display("FAIL clear_accept_ch9 got=%0d exp=7", chan(9));
        else n_pass++;
        n_checks++;
        if (ptr !== 4'd0) $display("FAIL clear_accept_ptr got=%0d exp=0", ptr);
        else n_pass++;
    endtask

`ifdef DEMUX16_COUNT_EN
    task automatic test_count();
        int w;
        ptr_clear = 1'b1;
        @(posedge clock); #1;
        ptr_clear = 1'b0;
        m_ptr = '0;
        n_checks++;
        if (accept_count !== 16'd0) $display("FAIL cnt_clr0 got=%0d exp=0", accept_count);
        else n_pass++;
        for (int i = 0; i < 20; i++)
            send(32'(300 + i), 4'd0, 1'b1, 16'hFFFF, 1'b0, w);
        // channel 3 now holds word 319; stall on it for 4 cycles
        in_data   = 32'h5;
        select    = 4'd3;
        auto_mode = 1'b0;
        in_valid  = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (accept_count !== 16'd20) $display("FAIL accept_count got=%0d exp=20", accept_count);
        else n_pass++;
        n_checks++;
        if (stall_cycles !== 16'd4) $display("FAIL stall_cycles got=%0d exp=4", stall_cycles);
        else n_pass++;
        ptr_clear = 1'b1;
        @(posedge clock); #1;
        ptr_clear = 1'b0;
        m_ptr = '0;
        n_checks++;
        if (accept_count !== 16'd0 || stall_cycles !== 16'd0)
            $display("FAIL cnt_clear got=%0d/%0d exp=0/0", accept_count, stall_cycles);
        else n_pass++;
    endtask
`endif

    task automatic test_reset_midstream();
        int w;
        send(32'hC0DE_0007, 4'd7, 1'b0, 16'h0000, 1'b0, w);
        in_data  = 32'hDEAD_0008;
        select   = 4'd8;
        in_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 16'h0000) $display("FAIL midreset_valid got=%h exp=0000", out_valid);
        else n_pass++;
        n_checks++;
        if (out_data !== '0) $display("FAIL midreset_data got nonzero exp=0");
        else n_pass++;
        n_checks++;
        if (ptr !== 4'd0) $display("FAIL midreset_ptr got=%0d exp=0", ptr);
        else n_pass++;
        @(negedge clock);
        in_valid = 1'b0;
        reset    = 1'b1;
        m_ptr    = '0;
        @(posedge clock); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 16'h0000)
            $display("FAIL midreset_release ready=%b valid=%h exp=1/0000", in_ready, out_valid);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_scatter();
        test_auto_wrap();
        test_back_to_back();
        test_ptr_clear();
`ifdef DEMUX16_COUNT_EN
        test_count();
`endif
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
